// File: rtl/pwls_pkg.sv
// Shared definitions for the pwls output mixer: accumulator sizing, the
// offset-binary midscale value and the mixer state encoding.
package pwls_pkg;

  localparam int DEFAULT_OUT_BITS = 8;
  localparam int MIX_MIDSCALE     = 1 << (DEFAULT_OUT_BITS - 1);

  typedef enum logic {
    ACCUM  = 1'b0,
    COMMIT = 1'b1
  } mixer_state_t;

  // Wide enough that NUM_CHANNELS full-scale samples can never overflow.
  function automatic int acc_bits(input int bits, input int num_channels);
    return bits + $clog2(num_channels);
  endfunction

  function automatic int mix_midscale(input int out_bits);
    return 1 << (out_bits - 1);
  endfunction

endpackage

// File: rtl/pwls_sigma_delta.sv
// First-order sigma-delta modulator: the carry out of an OUT_BITS error
// accumulator forms a PDM stream whose density equals din / 2^OUT_BITS.
module pwls_sigma_delta #(
  parameter int OUT_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OUT_BITS-1:0] din,
  output logic                pdm_out
);

  logic [OUT_BITS-1:0] err_q, err_d;
  logic                pdm_q, pdm_d;
  logic [OUT_BITS:0]   sum;

  always_comb begin
    sum   = {1'b0, err_q} + {1'b0, din};
    err_d = sum[OUT_BITS-1:0];
    pdm_d = sum[OUT_BITS];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
      pdm_q <= 1'b0;
    end else begin
      err_q <= err_d;
      pdm_q <= pdm_d;
    end
  end

  assign pdm_out = pdm_q;

endmodule

// File: rtl/pwls_output_mixer.sv
// Frame mixer: sums one sample per channel, scales by 2^gain with saturation,
// latches an offset-binary mix word per frame and drives it to a PDM pin.
module pwls_output_mixer
  import pwls_pkg::*;
#(
  parameter int BITS         = 12,
  parameter int NUM_CHANNELS = 4,
  parameter int OUT_BITS     = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sample_valid,
  input  logic [BITS-1:0]                 sample_in,
  output logic                            sample_ready,
  input  logic [1:0]                      gain,
  output logic [$clog2(NUM_CHANNELS)-1:0] ch_index,
  output logic [OUT_BITS-1:0]             mix_out,
  output logic                            mix_valid,
  output logic                            clip,
  output logic                            pdm_out
);

  localparam int ACC_BITS = acc_bits(BITS, NUM_CHANNELS);
  localparam int IDX_BITS = $clog2(NUM_CHANNELS);
  localparam int SHIFT    = ACC_BITS - OUT_BITS;
  localparam int SC_BITS  = ACC_BITS + 3;

  localparam logic [IDX_BITS-1:0]        LAST_IDX = IDX_BITS'(NUM_CHANNELS - 1);
  localparam logic [OUT_BITS-1:0]        MIDSCALE = OUT_BITS'(mix_midscale(OUT_BITS));
  localparam logic signed [SC_BITS-1:0]  SAT_HI   = SC_BITS'((1 << (OUT_BITS - 1)) - 1);
  localparam logic signed [SC_BITS-1:0]  SAT_LO   = ~SAT_HI;

  mixer_state_t                 state_q, state_d;
  logic signed [ACC_BITS-1:0]   acc_q, acc_d;
  logic [IDX_BITS-1:0]          idx_q, idx_d;
  logic [OUT_BITS-1:0]          mix_q, mix_d;
  logic                         clip_q, clip_d;
  logic                         mvalid_q, mvalid_d;

  logic signed [ACC_BITS-1:0]   sample_ext;
  logic signed [SC_BITS-1:0]    scaled;
  logic signed [SC_BITS-1:0]    m;

  assign sample_ext = {{(ACC_BITS - BITS){sample_in[BITS-1]}}, sample_in};

  // Three guard bits keep the gain shift exact before the range check.
  always_comb begin
    scaled = {{3{acc_q[ACC_BITS-1]}}, acc_q} <<< gain;
    m      = scaled >>> SHIFT;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    mix_d    = mix_q;
    clip_d   = clip_q;
    mvalid_d = 1'b0;
    case (state_q)
      ACCUM: begin
        if (sample_valid) begin
          acc_d = acc_q + sample_ext;
          idx_d = idx_q + IDX_BITS'(1);
          if (idx_q == LAST_IDX) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        mvalid_d = 1'b1;
        acc_d    = '0;
        state_d  = ACCUM;
        // Offset binary is the two's-complement value with its sign bit flipped.
        if (m > SAT_HI) begin
          mix_d  = '1;
          clip_d = 1'b1;
        end else if (m < SAT_LO) begin
          mix_d  = '0;
          clip_d = 1'b1;
        end else begin
          mix_d  = {~m[OUT_BITS-1], m[OUT_BITS-2:0]};
          clip_d = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      idx_q    <= '0;
      mix_q    <= MIDSCALE;
      clip_q   <= 1'b0;
      mvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      mix_q    <= mix_d;
      clip_q   <= clip_d;
      mvalid_q <= mvalid_d;
    end
  end

  assign sample_ready = (state_q == ACCUM);
  assign ch_index     = idx_q;
  assign mix_out      = mix_q;
  assign clip         = clip_q;
  assign mix_valid    = mvalid_q;

  pwls_sigma_delta #(
    .OUT_BITS(OUT_BITS)
  ) u_sigma_delta (
    .clk    (clk),
    .reset  (reset),
    .din    (mix_q),
    .pdm_out(pdm_out)
  );

endmodule

// File: tb/tb_pwls_output_mixer.sv
// Self-checking bench for pwls_output_mixer: a frame-level reference model
// compared every cycle, plus directed frames with hand-computed results.
module tb_pwls_output_mixer;

  localparam int BITS     = 12;
  localparam int N        = 4;
  localparam int OUT_BITS = 8;
  localparam int IDX_BITS = $clog2(N);

  logic                clk = 1'b0;
  logic                reset;
  logic                sample_valid;
  logic [BITS-1:0]     sample_in;
  logic                sample_ready;
  logic [1:0]          gain;
  logic [IDX_BITS-1:0] ch_index;
  logic [OUT_BITS-1:0] mix_out;
  logic                mix_valid;
  logic                clip;
  logic                pdm_out;

  int  tests    = 0;
  int  failures = 0;
  bit  checking = 1'b0;
  int  mvCount  = 0;

  int  q[$];
  bit  inCommit = 1'b0;
  int  expMix = 128, expClip = 0, expMvalid = 0, expPdm = 0;
  int  expReady = 1, expIdx = 0, errAcc = 0;

  bit  hist[512];

  always #5 clk = ~clk;

  pwls_output_mixer #(
    .BITS        (BITS),
    .NUM_CHANNELS(N),
    .OUT_BITS    (OUT_BITS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample_in   (sample_in),
    .sample_ready(sample_ready),
    .gain        (gain),
    .ch_index    (ch_index),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .clip        (clip),
    .pdm_out     (pdm_out)
  );

  function automatic int floorDiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [BITS-1:0] s, input logic [1:0] g);
    sample_valid = v;
    sample_in    = s;
    gain         = g;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a list of accepted samples per frame; the frame is mixed
  // with integer floor division and offset by midscale in the cycle after it fills.
  always @(posedge clk) begin : model
    int sum, m, t;
    if (reset) begin
      q.delete();
      inCommit  = 1'b0;
      expMix    = 128;
      expClip   = 0;
      expMvalid = 0;
      expPdm    = 0;
      errAcc    = 0;
    end else begin
      t         = errAcc + expMix;
      expPdm    = (t >= 256) ? 1 : 0;
      errAcc    = t % 256;
      expMvalid = 0;
      if (inCommit) begin
        sum = 0;
        foreach (q[i]) sum += q[i];
        m = floorDiv(sum * (1 << gain), 64);
        if (m > 127) begin
          expMix  = 255;
          expClip = 1;
        end else if (m < -128) begin
          expMix  = 0;
          expClip = 1;
        end else begin
          expMix  = m + 128;
          expClip = 0;
        end
        expMvalid = 1;
        q.delete();
        inCommit = 1'b0;
      end else if (sample_valid) begin
        q.push_back(int'($signed(sample_in)));
        if (q.size() == N) inCommit = 1'b1;
      end
    end
    expReady = inCommit ? 0 : 1;
    expIdx   = q.size() % N;
  end

  always @(negedge clk) begin
    if (mix_valid === 1'b1) mvCount++;
    if (checking) begin
      checkOutput("sample_ready", int'(sample_ready), expReady);
      checkOutput("ch_index",     int'(ch_index),     expIdx);
      checkOutput("mix_out",      int'(mix_out),      expMix);
      checkOutput("clip",         int'(clip),         expClip);
      checkOutput("mix_valid",    int'(mix_valid),    expMvalid);
      checkOutput("pdm_out",      int'(pdm_out),      expPdm);
    end
  end

  task automatic runFrame(input int val, input logic [1:0] g, input logic holdValid,
                          input int mixLit, input int clipLit, input string tag);
    int mvBefore;
    mvBefore = mvCount;
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b1, BITS'(val), 2'($urandom_range(0, 3)));
    end
    checkOutput({tag, "_ready_low"}, int'(sample_ready), 0);
    applyStimulus(holdValid, BITS'(val), g);
    checkOutput({tag, "_mix"},       int'(mix_out),      mixLit);
    checkOutput({tag, "_clip"},      int'(clip),         clipLit);
    checkOutput({tag, "_mvalid"},    int'(mix_valid),    1);
    checkOutput({tag, "_ready"},     int'(sample_ready), 1);
    checkOutput({tag, "_idx"},       int'(ch_index),     0);
    applyStimulus(1'b0, '0, 2'd0);
    checkOutput({tag, "_mvalid_end"}, int'(mix_valid), 0);
    checkOutput({tag, "_pulses"},     mvCount - mvBefore, 1);
  endtask

  initial begin : stimulus
    int ones, bad, mvBefore;
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_in    = '0;
    gain         = 2'd0;
    @(posedge clk);
    #1;
    checking = 1'b1;
    checkOutput("rst_mix",    int'(mix_out),      128);
    checkOutput("rst_clip",   int'(clip),         0);
    checkOutput("rst_mvalid", int'(mix_valid),    0);
    checkOutput("rst_pdm",    int'(pdm_out),      0);
    checkOutput("rst_idx",    int'(ch_index),     0);
    checkOutput("rst_ready",  int'(sample_ready), 1);
    reset = 1'b0;

    // Idle at midscale: alternating bitstream starting with 0.
    @(posedge clk);
    ones = 0;
    bad  = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pdm_out) ones++;
      if (int'(pdm_out) != (i % 2)) bad++;
    end
    checkOutput("idle_ones", ones, 128);
    checkOutput("idle_alternation_errs", bad, 0);
    @(posedge clk);
    #1;

    runFrame(100,   2'd0, 1'b0, 134, 0, "p100_g0");
    runFrame(100,   2'd3, 1'b0, 178, 0, "p100_g3");
    runFrame(-1,    2'd0, 1'b0, 127, 0, "m1_floor");
    runFrame(2047,  2'd0, 1'b0, 255, 0, "max_g0");
    runFrame(2047,  2'd1, 1'b0, 255, 1, "max_g1");
    runFrame(-2048, 2'd0, 1'b0, 0,   0, "min_g0");
    runFrame(-2048, 2'd1, 1'b0, 0,   1, "min_g1");

    // Reset mid-frame discards the partial sum and yields no pulse for it.
    mvBefore = mvCount;
    applyStimulus(1'b1, BITS'(50), 2'd0);
    applyStimulus(1'b1, BITS'(50), 2'd0);
    reset = 1'b1;
    applyStimulus(1'b0, '0, 2'd0);
    reset = 1'b0;
    checkOutput("midrst_idx", int'(ch_index), 0);
    runFrame(100, 2'd0, 1'b0, 134, 0, "after_rst");
    checkOutput("midrst_pulses", mvCount - mvBefore, 1);

    runFrame(100, 2'd0, 1'b1, 134, 0, "hold_valid");

    // 4 x 1152 = 4608 -> 4608 >> 6 = 72 -> mix word 200.
    runFrame(1152, 2'd0, 1'b0, 200, 0, "pdm200");
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      hist[i] = pdm_out;
    end
    bad = 0;
    for (int w = 0; w <= 256; w++) begin
      ones = 0;
      for (int k = 0; k < 256; k++) ones += int'(hist[w + k]);
      if (w == 0) checkOutput("pdm200_first_window", ones, 200);
      if (ones != 200) bad++;
    end
    checkOutput("pdm200_bad_windows", bad, 0);
    @(posedge clk);
    #1;

    // Random traffic with valid gaps, random gain and occasional resets.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      applyStimulus(logic'($urandom_range(0, 9) < 7), BITS'($urandom), 2'($urandom_range(0, 3)));
    end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 2'd0);

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
